wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning register-file address width.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  5  write-back requests; bit i = source whose write_data_src code is i (0 ALU, 1 mem, 2 data_rg, 3 mem_rg, 4 imm).
REQ-005 SHALL have ports dst_alu, dst_mem, dst_data_rg, dst_mem_rg, dst_imm  input  ADDR_W each  destination register of the matching requester.
REQ-006 SHALL have port stall  input  1  pipeline stall; blocks new grants.
REQ-007 SHALL have port gnt  output  5  one-hot grant, registered.
REQ-008 SHALL have port write_data_src  output  3  select code for the write-data mux, registered.
REQ-009 SHALL have port write_addr  output  ADDR_W  register-file write address, registered.
REQ-010 SHALL have port reg_write  output  1  register-file write enable, registered.
REQ-011 SHALL have port contend  output  1  registered flag: last arbitration left at least one eligible request ungranted.

Function
REQ-012 SHALL sample req, dst_* and stall on each rising clk edge and drive the outcome on gnt/write_data_src/write_addr/reg_write for the following cycle (latency 1).
REQ-013 SHALL assert at most one gnt bit per cycle; reg_write = OR of gnt.
REQ-014 With gnt[i]=1, write_data_src SHALL equal i (3'b000..3'b100) and write_addr SHALL equal the dst_* of source i sampled at the arbitration edge.
REQ-015 With no grant, gnt=0, reg_write=0, write_data_src=3'b000, write_addr=0.
REQ-016 A source granted in cycle c SHALL be ineligible at the arbitration edge ending cycle c; consecutive writes from one source therefore occur no faster than every other cycle.
REQ-017 Requesters SHALL hold req and dst stable until gnt seen; the arbiter SHALL NOT depend on req dropping earlier.
REQ-018 stall=1 at an edge SHALL produce no grant next cycle; the round-robin pointer and pending requests SHALL be unaffected.
REQ-019 Arbitration policy SHALL be as selected by REQ-025/REQ-026; eligible set = req with REQ-016 mask applied.
REQ-020 contend SHALL be 1 next cycle iff, at the edge, stall=0 and eligible requests numbered two or more; stall=1 SHALL force contend=0.
REQ-021 Request bits for unused source codes 5-7 do not exist; write_data_src SHALL never exceed 3'b100.

Reset
REQ-022 rst_n=0 SHALL immediately force gnt=0, reg_write=0, write_data_src=3'b000, write_addr=0, contend=0, grant mask=0, round-robin pointer=4.
REQ-023 Reset asserted during a grant cycle SHALL cancel that write combinationally-from-reset (reg_write low before next edge).
REQ-024 First edge after rst_n release SHALL arbitrate normally; ALU wins any first-cycle contention under both policies.

Configuration
REQ-025 Macro WB_ARB_RR_EN defined: round-robin; search starts at (last granted index + 1) mod 5, wrapping 4->0; pointer updates only on a grant.
REQ-026 Macro WB_ARB_RR_EN undefined: fixed priority, lowest index wins (ALU highest, imm lowest); pointer logic absent; REQ-016 mask still applies.

Verification
REQ-027 Reset then req=5'b00001, dst_alu=3 -> next cycle gnt=5'b00001, write_data_src=000, write_addr=3, reg_write=1; following cycle (req held) gnt=0.
REQ-028 RR build, req=5'b11111 held, all dst=i+8 -> grants ALU, mem, data_rg, mem_rg, imm, ALU in consecutive cycles, write_addr 8,9,10,11,12,8, contend=1 throughout.
REQ-029 Fixed build, req=5'b10010 held -> grants mem, imm, mem, imm alternating (mask), never ALU; write_data_src 001,100 alternating.
REQ-030 req=5'b00100 with stall=1 for 3 edges then stall=0 -> gnt=0 and contend=0 for 3 cycles, then gnt=5'b00100, write_data_src=010.
REQ-031 rst_n pulled low mid-cycle while gnt=5'b01000 -> gnt, reg_write, write_addr go 0 before next edge; after release with req=5'b11000, RR build grants mem_rg first (pointer 4 -> start 0, ALU absent).

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Write-back arbitration bus: requests, destination addresses and stall from
// the pipeline; grant, write-data select and register-file write port back.
interface wb_arbiter_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [4:0]        req;
  logic [ADDR_W-1:0] dst_alu;
  logic [ADDR_W-1:0] dst_mem;
  logic [ADDR_W-1:0] dst_data_rg;
  logic [ADDR_W-1:0] dst_mem_rg;
  logic [ADDR_W-1:0] dst_imm;
  logic              stall;
  logic [4:0]        gnt;
  logic [2:0]        write_data_src;
  logic [ADDR_W-1:0] write_addr;
  logic              reg_write;
  logic              contend;

  // Requester side
  modport master (
    output req, dst_alu, dst_mem, dst_data_rg, dst_mem_rg, dst_imm, stall,
    input  gnt, write_data_src, write_addr, reg_write, contend
  );

  // Arbiter side
  modport slave (
    input  req, dst_alu, dst_mem, dst_data_rg, dst_mem_rg, dst_imm, stall,
    output gnt, write_data_src, write_addr, reg_write, contend
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back port arbiter for five sources (ALU, mem, data_rg, mem_rg, imm).
// One registered grant per cycle; a source granted last cycle is masked off.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority
// with the ALU highest and imm lowest.
module wb_arbiter #(
  parameter int unsigned ADDR_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  logic [4:0]        elig;
  logic [2:0]        elig_cnt;
  logic              win_vld;
  logic [2:0]        win_idx;
  logic [ADDR_W-1:0] win_dst;

  logic [4:0]        gnt_q, gnt_d;
  logic [2:0]        src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              contend_q, contend_d;

`ifdef WB_ARB_RR_EN
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] cand;

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i >= 3'd4) ? 3'd0 : i + 3'd1;
  endfunction
`endif

  // Last cycle's grant doubles as the back-to-back mask.
  assign elig     = bus.req & ~gnt_q;
  assign elig_cnt = {2'b00, elig[0]} + {2'b00, elig[1]} + {2'b00, elig[2]} +
                    {2'b00, elig[3]} + {2'b00, elig[4]};

  // Pick the winner among eligible requests.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 3'd0;
`ifdef WB_ARB_RR_EN
    // Search starts one past the last granted source, wrapping 4 -> 0.
    cand = next_idx(ptr_q);
    for (int k = 0; k < 5; k++) begin
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
      cand = next_idx(cand);
    end
`else
    for (int i = 0; i < 5; i++) begin
      if (!win_vld && elig[i]) begin
        win_vld = 1'b1;
        win_idx = 3'(i);
      end
    end
`endif
  end

  // Destination address of the winning source.
  always_comb begin
    unique case (win_idx)
      3'd0:    win_dst = bus.dst_alu;
      3'd1:    win_dst = bus.dst_mem;
      3'd2:    win_dst = bus.dst_data_rg;
      3'd3:    win_dst = bus.dst_mem_rg;
      3'd4:    win_dst = bus.dst_imm;
      default: win_dst = '0;
    endcase
  end

  // Next-state for the registered write port; stall suppresses grant and contend.
  always_comb begin
    gnt_d     = '0;
    src_d     = 3'd0;
    addr_d    = '0;
    we_d      = 1'b0;
    contend_d = !bus.stall && (elig_cnt >= 3'd2);
`ifdef WB_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    if (!bus.stall && win_vld) begin
      gnt_d  = 5'b00001 << win_idx;
      src_d  = win_idx;
      addr_d = win_dst;
      we_d   = 1'b1;
`ifdef WB_ARB_RR_EN
      ptr_d  = win_idx;
`endif
    end
  end

  // State registers; async reset cancels any in-flight write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      src_q     <= 3'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      contend_q <= 1'b0;
`ifdef WB_ARB_RR_EN
      ptr_q     <= 3'd4;
`endif
    end else begin
      gnt_q     <= gnt_d;
      src_q     <= src_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      contend_q <= contend_d;
`ifdef WB_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.write_data_src = src_q;
  assign bus.write_addr     = addr_q;
  assign bus.reg_write      = we_q;
  assign bus.contend        = contend_q;

endmodule
